// File: rtl/ps2_key_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder_pkg
//   Shared constants for the PS/2 keyboard front end:
//     - 4-bit key codes consumed by the player control blocks
//     - PS/2 set-2 scan codes of interest
//     - receiver frame FSM state encoding
//     - scan_to_key(): scan code -> key code (key_NONE when unmapped)
// ---------------------------------------------------------------------------
package ps2_key_decoder_pkg;

   localparam logic [3:0] key_NONE  = 4'h0;
   localparam logic [3:0] key_W     = 4'h1;
   localparam logic [3:0] key_A     = 4'h2;
   localparam logic [3:0] key_S     = 4'h3;
   localparam logic [3:0] key_D     = 4'h4;
   localparam logic [3:0] key_SPACE = 4'h5;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_SPACE = 8'h29;

   typedef enum logic [1:0] {
      RX_IDLE   = 2'd0,
      RX_DATA   = 2'd1,
      RX_PARITY = 2'd2,
      RX_STOP   = 2'd3
   } rx_state_e;

   function automatic logic [3:0] scan_to_key(input logic [7:0] sc);
      logic [3:0] k;
      case (sc)
         SC_W:     k = key_W;
         SC_A:     k = key_A;
         SC_S:     k = key_S;
         SC_D:     k = key_D;
         SC_SPACE: k = key_SPACE;
         default:  k = key_NONE;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/ps2_key_decoder_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx
//   PS/2 byte receiver: 2-FF synchronisers on both pins, a stability filter
//   on ps2_clk, an 11-bit frame FSM (start, 8 data LSB first, odd parity,
//   stop) clocked by falling edges of the filtered clock, and a mid-frame
//   idle timeout.
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   ps2_clk/data    raw asynchronous PS/2 pins
//   rx_byte         last correctly framed byte (registered)
//   rx_valid        1-cycle pulse, rx_byte updated
//   frame_err       1-cycle pulse, frame discarded
//   byte_stb        combinational strobe in the STOP sample cycle of a good
//                   frame; lets the key register update alongside rx_valid
//   byte_nxt        byte being accepted when byte_stb is high
// ---------------------------------------------------------------------------
module ps2_rx
   import ps2_key_decoder_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 65000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       byte_stb,
   output logic [7:0] byte_nxt
);

   localparam int FW   = $clog2(FILTER_LEN) + 1;
   localparam int TO_W = 17;

   logic            clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
   logic            dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
   logic            filt_q, filt_d;
   logic [FW-1:0]   flt_cnt_q, flt_cnt_d;
   logic            flt_settle, smp_evt;
   rx_state_e       state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      sh_q, sh_d;
   logic            par_ok_q, par_ok_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            to_hit;
   logic [7:0]      rx_byte_q, rx_byte_d;
   logic            rx_valid_q, rx_valid_d;
   logic            frame_err_q, frame_err_d;

   // Synchronisers and ps2_clk filter. The filtered level flips only when
   // the synchronised clock has disagreed with it for FILTER_LEN cycles in a
   // row; any agreeing sample restarts the count, so short glitches vanish.
   always_comb begin
      clk_s1_d   = ps2_clk;
      clk_s2_d   = clk_s1_q;
      dat_s1_d   = ps2_data;
      dat_s2_d   = dat_s1_q;
      filt_d     = filt_q;
      flt_cnt_d  = '0;
      flt_settle = (clk_s2_q != filt_q) && (flt_cnt_q == FW'(FILTER_LEN - 1));
      if (clk_s2_q != filt_q) begin
         if (flt_settle) filt_d = clk_s2_q;
         else            flt_cnt_d = flt_cnt_q + 1'b1;
      end
      // Falling edge of the filtered clock: one frame bit.
      smp_evt = flt_settle && filt_q;
   end

   // Timeout counts cycles since the last sample event while mid-frame.
   always_comb begin
      to_hit   = (state_q != RX_IDLE) && !smp_evt &&
                 (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
      to_cnt_d = (state_q == RX_IDLE || smp_evt || to_hit) ? '0 : to_cnt_q + 1'b1;
   end

   // Frame FSM: state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= RX_IDLE;
      else     state_q <= state_d;
   end

   // Frame FSM: next state.
   always_comb begin
      state_d = state_q;
      if (to_hit) begin
         state_d = RX_IDLE;
      end else if (smp_evt) begin
         case (state_q)
            RX_IDLE:   if (!dat_s2_q) state_d = RX_DATA;
            RX_DATA:   if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
            RX_PARITY: state_d = RX_STOP;
            RX_STOP:   state_d = RX_IDLE;
            default:   state_d = RX_IDLE;
         endcase
      end
   end

   // Frame FSM: outputs.
   always_comb begin
      byte_stb    = smp_evt && (state_q == RX_STOP) && dat_s2_q && par_ok_q;
      byte_nxt    = sh_q;
      frame_err_d = to_hit ||
                    (smp_evt && (state_q == RX_IDLE) && dat_s2_q) ||
                    (smp_evt && (state_q == RX_STOP) && !(dat_s2_q && par_ok_q));
      rx_valid_d  = byte_stb;
      rx_byte_d   = byte_stb ? sh_q : rx_byte_q;
   end

   // Frame datapath: shift register, bit counter, parity result.
   always_comb begin
      bit_cnt_d = bit_cnt_q;
      sh_d      = sh_q;
      par_ok_d  = par_ok_q;
      if (smp_evt) begin
         case (state_q)
            RX_IDLE:   bit_cnt_d = '0;
            RX_DATA: begin
               sh_d      = {dat_s2_q, sh_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
            RX_PARITY: par_ok_d = ^{sh_q, dat_s2_q};
            default:   ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1_q    <= 1'b1;
         clk_s2_q    <= 1'b1;
         dat_s1_q    <= 1'b1;
         dat_s2_q    <= 1'b1;
         filt_q      <= 1'b1;
         flt_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         sh_q        <= '0;
         par_ok_q    <= 1'b0;
         to_cnt_q    <= '0;
         rx_byte_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         clk_s1_q    <= clk_s1_d;
         clk_s2_q    <= clk_s2_d;
         dat_s1_q    <= dat_s1_d;
         dat_s2_q    <= dat_s2_d;
         filt_q      <= filt_d;
         flt_cnt_q   <= flt_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         sh_q        <= sh_d;
         par_ok_q    <= par_ok_d;
         to_cnt_q    <= to_cnt_d;
         rx_byte_q   <= rx_byte_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rx_byte   = rx_byte_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
//   Keyboard front end. Turns PS/2 set-2 scan codes into the 4-bit key code
//   used by the game logic; holds the last pressed mapped key until its
//   break code arrives.
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   ps2_clk/data    raw asynchronous PS/2 pins
//   key             current key code, key_NONE when no mapped key held
//   rx_byte         last correctly framed byte
//   rx_valid        1-cycle pulse, rx_byte updated
//   frame_err       1-cycle pulse, frame discarded
// ---------------------------------------------------------------------------
module ps2_key_decoder
   import ps2_key_decoder_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 65000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [3:0] key,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       frame_err
);

   logic       byte_stb;
   logic [7:0] byte_nxt;
   logic [3:0] key_q, key_d;
   logic       brk_q, brk_d;
   logic       ext_q, ext_d;
   logic [3:0] mapped;

   ps2_rx #(
      .FILTER_LEN  (FILTER_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_rx (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .byte_stb  (byte_stb),
      .byte_nxt  (byte_nxt)
   );

   // Decode on the receiver's pre-register strobe so key and rx_valid move
   // in the same cycle. Error frames never strobe, so a pending break
   // survives them and is consumed by the next good byte.
   always_comb begin
      key_d  = key_q;
      brk_d  = brk_q;
      ext_d  = ext_q;
      mapped = scan_to_key(byte_nxt);
      if (byte_stb) begin
         if (byte_nxt == SC_BREAK) begin
            brk_d = 1'b1;
         end else if (byte_nxt == SC_EXT) begin
            ext_d = 1'b1;
         end else if (ext_q) begin
            // Extended keys are not used; drop the code and any break prefix.
            ext_d = 1'b0;
            brk_d = 1'b0;
         end else if (brk_q) begin
            if (mapped == key_q) key_d = key_NONE;
            brk_d = 1'b0;
         end else if (mapped != key_NONE) begin
            key_d = mapped;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_q <= key_NONE;
         brk_q <= 1'b0;
         ext_q <= 1'b0;
      end else begin
         key_q <= key_d;
         brk_q <= brk_d;
         ext_q <= ext_d;
      end
   end

   assign key = key_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed vector table, hand
// sequences for timeout / glitch / mid-frame reset, and random frames
// checked against a prefix-queue reference model.
module tb_ps2_key_decoder;

   localparam int FL   = 8;
   localparam int TO   = 2000;
   localparam int HALF = 40;

   localparam logic [3:0] KN = 4'h0, KW = 4'h1, KA = 4'h2, KS = 4'h3, KD = 4'h4, KSP = 4'h5;

   logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic [3:0] key;
   logic [7:0] rx_byte;
   logic       rx_valid, frame_err;

   always #5 clk = ~clk;

   ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key(key), .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err)
   );

   typedef struct {
      logic [7:0] b;
      int         kind;   // 0 good, 1 bad parity, 2 bad stop, 3 lone start=1 pulse
      logic [3:0] ekey;
      int         evalid;
      int         eerr;
   } vec_t;

   vec_t       vq[$];
   int         n_cmp = 0, n_fail = 0;
   int         n_valid = 0, n_err = 0;
   logic [3:0] key_at_valid = 4'h0;

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid) begin
            n_valid++;
            key_at_valid = key;
         end
         if (frame_err) n_err++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic ps2_bit(input logic v, input bit glitch);
      ps2_data = v;
      if (glitch) begin
         cyc(HALF / 2);
         ps2_clk = 1'b0;
         cyc(FL - 3);
         ps2_clk = 1'b1;
         cyc(HALF - HALF / 2 - (FL - 3));
      end else begin
         cyc(HALF);
      end
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send(input logic [7:0] b, input int kind, input int nbits, input int gbit);
      logic [10:0] fr;
      fr[0]    = (kind == 3);
      fr[8:1]  = b;
      fr[9]    = (~^b) ^ (kind == 1);
      fr[10]   = (kind != 2);
      for (int i = 0; i < nbits; i++) ps2_bit(fr[i], i == gbit);
      ps2_data = 1'b1;
      cyc(HALF);
   endtask

   task automatic apply(input string nm, input logic [7:0] b, input int kind,
                        input logic [3:0] ekey, input int evalid, input int eerr, input int gbit);
      int v0, e0;
      v0 = n_valid;
      e0 = n_err;
      send(b, kind, (kind == 3) ? 1 : 11, gbit);
      cyc(20);
      @(negedge clk);
      chk({nm, " valid"}, n_valid - v0, evalid);
      chk({nm, " err"},   n_err - e0,   eerr);
      chk({nm, " key"},   key,          ekey);
      if (evalid != 0) begin
         chk({nm, " rx_byte"},   rx_byte,      b);
         chk({nm, " key@valid"}, key_at_valid, ekey);
      end
   endtask

   function automatic logic [3:0] ref_map(input logic [7:0] b);
      if (b == 8'h1D) return KW;
      if (b == 8'h1C) return KA;
      if (b == 8'h1B) return KS;
      if (b == 8'h23) return KD;
      if (b == 8'h29) return KSP;
      return KN;
   endfunction

   task automatic add(input logic [7:0] b, input int kind, input logic [3:0] ekey);
      vec_t v;
      v.b = b; v.kind = kind; v.ekey = ekey;
      v.evalid = (kind == 0) ? 1 : 0;
      v.eerr   = (kind == 0) ? 0 : 1;
      vq.push_back(v);
   endtask

   initial begin
      logic [7:0] pfx[$];
      logic [3:0] mkey;
      int         v0, e0;
      bit         has_f0, has_e0;

      add(8'h1D,0,KW);  add(8'hF0,0,KW);  add(8'h1D,0,KN);  add(8'h1D,0,KW);
      add(8'hF0,0,KW);  add(8'h1C,1,KW);  add(8'h1C,0,KW);  add(8'hF0,0,KW);
      add(8'h1D,0,KN);  add(8'hE0,0,KN);  add(8'h1D,0,KN);  add(8'h1B,0,KS);
      add(8'h1C,0,KA);  add(8'h23,0,KD);  add(8'hF0,0,KD);  add(8'h1C,0,KD);
      add(8'hF0,0,KD);  add(8'h23,0,KN);  add(8'h5A,0,KN);  add(8'h1D,0,KW);
      add(8'h5A,0,KW);  add(8'h1D,0,KW);  add(8'hE0,0,KW);  add(8'hF0,0,KW);
      add(8'h1D,0,KW);  add(8'h29,2,KW);  add(8'h00,3,KW);  add(8'h29,0,KSP);

      // reset state
      cyc(5);
      @(negedge clk);
      chk("reset key", key, KN);
      chk("reset rx_byte", rx_byte, 8'h00);
      chk("reset rx_valid", rx_valid, 1'b0);
      chk("reset frame_err", frame_err, 1'b0);
      rst = 1'b0;
      cyc(30);

      foreach (vq[i]) apply($sformatf("vec%0d", i), vq[i].b, vq[i].kind, vq[i].ekey,
                            vq[i].evalid, vq[i].eerr, -1);

      // timeout: start + 5 data bits, then the clock stops
      v0 = n_valid; e0 = n_err;
      send(8'h23, 0, 6, -1);
      cyc(TO + 500);
      @(negedge clk);
      chk("timeout err", n_err - e0, 1);
      chk("timeout valid", n_valid - v0, 0);
      chk("timeout key", key, KSP);
      apply("after timeout", 8'h23, 0, KD, 1, 0, -1);

      // short glitch on ps2_clk during a data bit must not create a sample
      apply("glitch", 8'h1B, 0, KS, 1, 0, 4);

      // reset mid-frame
      send(8'h29, 0, 4, -1);
      @(negedge clk);
      rst = 1'b1;
      cyc(3);
      @(negedge clk);
      chk("midrst key", key, KN);
      chk("midrst rx_byte", rx_byte, 8'h00);
      chk("midrst rx_valid", rx_valid, 1'b0);
      chk("midrst frame_err", frame_err, 1'b0);
      rst = 1'b0;
      cyc(30);
      apply("after reset", 8'h29, 0, KSP, 1, 0, -1);

      // random frames against the prefix-queue model
      @(negedge clk);
      rst = 1'b1;
      cyc(3);
      @(negedge clk);
      rst = 1'b0;
      cyc(30);
      mkey = KN;
      for (int n = 0; n < 30; n++) begin
         logic [7:0] b;
         int r, kind;
         r = $urandom_range(0, 9);
         case (r)
            0: b = 8'h1D; 1: b = 8'h1C; 2: b = 8'h1B; 3: b = 8'h23; 4: b = 8'h29;
            5: b = 8'hF0; 6: b = 8'hE0;
            default: b = 8'($urandom_range(0, 255));
         endcase
         kind = ($urandom_range(0, 9) == 0) ? 1 : 0;
         if (kind == 0) begin
            if (b == 8'hF0 || b == 8'hE0) begin
               pfx.push_back(b);
            end else begin
               has_f0 = 0; has_e0 = 0;
               foreach (pfx[j]) begin
                  if (pfx[j] == 8'hF0) has_f0 = 1;
                  if (pfx[j] == 8'hE0) has_e0 = 1;
               end
               if (!has_e0) begin
                  if (has_f0) begin
                     if (ref_map(b) == mkey) mkey = KN;
                  end else if (ref_map(b) != KN) begin
                     mkey = ref_map(b);
                  end
               end
               pfx.delete();
            end
         end
         apply($sformatf("rnd%0d_%02h", n, b), b, kind, mkey,
               (kind == 0) ? 1 : 0, (kind == 0) ? 0 : 1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
